// File: rtl/rglib_rotate_pipe.sv
// Two-stage pipelined barrel rotator with valid/ready handshakes on both sides.
// Stage 1 applies the coarse (high) part of the rotate amount, stage 2 the fine (low) part.
`timescale 1ns/1ps

module rglib_rotate_pipe #(
   parameter int DATA_W = 8,
   parameter int SH_W   = $clog2(DATA_W),
   parameter int SPLIT  = SH_W / 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [SH_W-1:0]   s_shift,
   input  logic              s_dir,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data
);

   generate
      if (DATA_W < 2 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_width
         $error("rglib_rotate_pipe: DATA_W must be a power of two >= 2");
      end
      if (SH_W != $clog2(DATA_W)) begin : g_bad_shw
         $error("rglib_rotate_pipe: SH_W is derived from DATA_W and must not be overridden");
      end
      if (SPLIT < 0 || SPLIT > SH_W) begin : g_bad_split
         $error("rglib_rotate_pipe: SPLIT must lie in 0..SH_W");
      end
   endgenerate

   // A zero SPLIT still keeps a one-bit lo1 register, masked to zero.
   localparam int              LO_W    = (SPLIT > 0) ? SPLIT : 1;
   localparam logic [SH_W-1:0] LO_MASK = SH_W'((1 << SPLIT) - 1);

   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] d,
                                              input logic [SH_W-1:0]   a);
      logic [2*DATA_W-1:0] wide;
      wide = {d, d} << a;
      return wide[2*DATA_W-1:DATA_W];
   endfunction

   logic              v1;
   logic              v2;
   logic [DATA_W-1:0] d1;
   logic [LO_W-1:0]   lo1;
   logic              adv1;
   logic              adv2;
   logic [SH_W-1:0]   amt;
   logic [SH_W-1:0]   hi_amt;
   logic [LO_W-1:0]   lo_amt;

   // A right rotate by n is a left rotate by (DATA_W - n) mod DATA_W; the mod is free in SH_W bits.
   always_comb begin
      amt    = s_dir ? ({SH_W{1'b0}} - s_shift) : s_shift;
      hi_amt = amt & ~LO_MASK;
      lo_amt = LO_W'(amt & LO_MASK);
   end

   assign adv2    = !v2 || m_ready;
   assign adv1    = !v1 || adv2;
   assign s_ready = adv1;
   assign m_valid = v2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         d1     <= '0;
         lo1    <= '0;
         m_data <= '0;
      end else begin
         if (adv2) begin
            v2 <= v1;
            if (v1) begin
               m_data <= rotl(d1, SH_W'(lo1));
            end
         end
         if (adv1) begin
            v1 <= s_valid;
            if (s_valid) begin
               d1  <= rotl(s_data, hi_amt);
               lo1 <= lo_amt;
            end
         end
      end
   end

endmodule

// File: tb/tb_rglib_rotate_pipe.sv
// Self-checking bench for rglib_rotate_pipe: directed vectors plus a queue-based scoreboard
// that predicts every output word from plain rotate arithmetic.
`timescale 1ns/1ps

module tb_rglib_rotate_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_data = 8'h00;
   logic [2:0] s_shift = 3'd0;
   logic       s_dir = 1'b0;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int xfers = 0;

   typedef struct {
      logic [7:0] data;
      int         cap;
   } exp_t;
   exp_t q[$];

   rglib_rotate_pipe #(.DATA_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .s_shift(s_shift),
      .s_dir(s_dir),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_rot(input logic [7:0] d, input int sh, input logic dir);
      int x;
      int r;
      x = int'(d);
      if (!dir) r = (x << sh) | (x >> (8 - sh));
      else      r = (x >> sh) | (x << (8 - sh));
      return 8'(r & 255);
   endfunction

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] sh,
                                input logic dir, input logic rdy);
      @(posedge clk);
      #1;
      s_valid = v;
      s_data  = d;
      s_shift = sh;
      s_dir   = dir;
      m_ready = rdy;
   endtask

   // Push one word into an empty pipe and pin its latency and value with literal expectations.
   task automatic directed(input string name, input logic [7:0] d, input logic [2:0] sh,
                           input logic dir, input logic [7:0] exp);
      applyStimulus(1'b1, d, sh, dir, 1'b1);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput({name, "_early_valid"}, 32'(m_valid), 32'd0);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput({name, "_valid"}, 32'(m_valid), 32'd1);
      checkOutput({name, "_data"}, 32'(m_data), 32'(exp));
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 0;
      while (q.size() != 0 && budget < 20) begin
         applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
         budget++;
      end
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput({name, "_drained"}, 32'(q.size()), 32'd0);
   endtask

   // Scoreboard: the oldest outstanding word must be visible from the second edge after capture.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            logic ev;
            ev = (q.size() > 0) && (cyc >= q[0].cap + 1);
            checkOutput("sb_m_valid", 32'(m_valid), 32'(ev));
            if (ev) checkOutput("sb_m_data", 32'(m_data), 32'(q[0].data));
            checkOutput("sb_s_ready", 32'(s_ready), 32'((q.size() < 2) || m_ready));
            if (m_valid && m_ready && q.size() > 0) begin
               void'(q.pop_front());
               xfers++;
            end
            if (s_valid && s_ready) begin
               q.push_back('{model_rot(s_data, int'(s_shift), s_dir), cyc + 1});
            end
            checkOutput("sb_occupancy", 32'(q.size() <= 2), 32'd1);
         end
      end
   end

   initial begin
      int base;
      int idx;
      logic [7:0] w[5];

      #3;
      checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
      checkOutput("reset_m_data", 32'(m_data), 32'd0);
      checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
      #9;
      rst_n = 1'b1;

      $display("[TB] directed rotates");
      directed("rotl_81_1", 8'h81, 3'd1, 1'b0, 8'h03);
      directed("rotr_81_1", 8'h81, 3'd1, 1'b1, 8'hC0);
      directed("rotr_A5_4", 8'hA5, 3'd4, 1'b1, 8'h5A);
      directed("rot_12_0", 8'h12, 3'd0, 1'b1, 8'h12);
      directed("rotl_3C_2", 8'h3C, 3'd2, 1'b0, 8'hF0);
      drain("directed");

      $display("[TB] throughput");
      base = xfers;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i * 37 + 5), 3'(i % 8), (i >= 8), 1'b1);
         checkOutput("tp_s_ready", 32'(s_ready), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput("tp_xfers_15", 32'(xfers - base), 32'd15);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput("tp_xfers_16", 32'(xfers - base), 32'd16);
      drain("throughput");

      $display("[TB] backpressure");
      w = '{8'h11, 8'h96, 8'hF0, 8'h3A, 8'hC7};
      base = xfers;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, w[idx], 3'(idx + 1), idx[0], 1'b0);
         @(negedge clk);
         if (s_ready) idx++;
      end
      checkOutput("bp_accepts", 32'(idx), 32'd2);
      for (int c = 0; c < 20 && idx < 5; c++) begin
         applyStimulus(1'b1, w[idx], 3'(idx + 1), idx[0], 1'b1);
         @(negedge clk);
         if (s_ready) idx++;
      end
      checkOutput("bp_all_accepted", 32'(idx), 32'd5);
      drain("backpressure");
      checkOutput("bp_xfers", 32'(xfers - base), 32'd5);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 8'hAA, 3'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h55, 3'd2, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      checkOutput("rst_pre_m_valid", 32'(m_valid), 32'd1);
      #5;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_async_m_data", 32'(m_data), 32'd0);
      checkOutput("rst_async_s_ready", 32'(s_ready), 32'd1);
      q.delete();
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      checkOutput("rst_no_ghost", 32'(m_valid), 32'd0);
      directed("post_rst", 8'h3C, 3'd2, 1'b0, 8'hF0);
      drain("reset");

      $display("[TB] random traffic");
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0));
      end
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
